// File: rtl/mult_unit.sv
// mult_unit: multi-cycle MULT/MULTU shift-add multiplier feeding HI/LO, one partial product per cycle.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module nadder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

module mult_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N);
    localparam int W2 = 2 * N;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [W2-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d, done_q, done_d;

    logic [N-1:0]  mag_a, mag_b, addend, sum;
    logic          cout, last;
    logic [W2:0]   stepped;
    logic [W2-1:0] prod, acc_next;

    assign mag_a  = (is_signed && a[N-1]) ? -a : a;
    assign mag_b  = (is_signed && b[N-1]) ? -b : b;
    assign addend = acc_q[0] ? mcand_q : '0;

    nadder #(.N(N)) u_add (
        .a   (acc_q[W2-1:N]),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // lower half holds the not-yet-consumed multiplier bits, LSB first
    assign stepped = {cout, sum, acc_q[N-1:0]};
    assign prod    = neg_q ? -acc_q : acc_q;

`ifdef MULT_EARLY_EXIT_EN
    localparam int CW1 = CW + 1;
    logic [N-1:0] rest;
    logic [CW:0]  rem;
    assign rest     = acc_q[N-1:0] & ({N{1'b1}} >> cnt_q) & {{(N-1){1'b1}}, 1'b0};
    assign rem      = CW1'(N) - {1'b0, cnt_q};
    assign last     = rest == '0;
    assign acc_next = W2'(stepped >> rem);
`else
    assign last     = cnt_q == CW'(N - 1);
    assign acc_next = W2'(stepped >> 1);
`endif

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                mcand_d = mag_a;
                acc_d   = {{N{1'b0}}, mag_b};
                cnt_d   = '0;
                neg_d   = is_signed && (a[N-1] ^ b[N-1]);
            end
            RUN: begin
                acc_d   = acc_next;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FINISH : RUN;
            end
            FINISH: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: scoreboard bench for mult_unit; expected products and done cycles come from 64-bit arithmetic.
module tb_mult_unit;
    localparam int N = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic         busy, done;
    logic [N-1:0] hi, lo;

    always #5 clk = ~clk;

    mult_unit #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0, n_chk = 0, n_fail = 0;
    logic [N-1:0] last_hi = '0, last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Shift-add steps: full width, or up to the top set bit of |b| when exiting early.
    function automatic int steps(input logic sg, input logic [N-1:0] bv);
        int s;
`ifdef MULT_EARLY_EXIT_EN
        logic [N-1:0] m;
        m = (sg && bv[N-1]) ? -bv : bv;
        s = 1;
        for (int i = 0; i < N; i++) if (m[i]) s = i + 1;
`else
        s = (sg || bv[0] || !bv[0]) ? N : N;
`endif
        return s;
    endfunction

    task automatic issue(input logic sg, input logic [N-1:0] av, input logic [N-1:0] bv, input bit b2b);
        logic signed [2*N-1:0] sa, sb, p;
        exp_t e;
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_wait", busy, 0);
        if (b2b) chk("b2b_in_done_cycle", done, 1);
        sa = sg ? {{N{av[N-1]}}, av} : {{N{1'b0}}, av};
        sb = sg ? {{N{bv[N-1]}}, bv} : {{N{1'b0}}, bv};
        p = sa * sb;
        e.hi = p[2*N-1:N];
        e.lo = p[N-1:0];
        e.due = cyc + 1 + steps(sg, bv) + 1;
        q.push_back(e);
        start = 1'b1;
        is_signed = sg;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int t = 0; q.size() != 0 && t < 200; t++) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                chk("busy_in_done", busy, 0);
                if (q.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    e = q.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("done_cycle", cyc, e.due);
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else begin
                chk("hold_hi", hi, last_hi);
                chk("hold_lo", lo, last_lo);
            end
        end
    end

    initial begin : driver
        logic [N-1:0] ra, rb;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, 32'd3, 32'd5, 0);
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        issue(1, 32'hFFFFFFFD, 32'd5, 0);
        issue(1, 32'h80000000, 32'h80000000, 0);
        issue(0, 32'd9, 32'd1, 0);
        issue(0, 32'd0, 32'd0, 0);
        issue(1, 32'h7FFFFFFF, 32'h80000000, 0);
        drain();
        // start pulse mid-operation must be dropped; then restart in the done cycle
        issue(0, 32'h00001234, 32'h80005678, 0);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd7;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        issue(1, 32'hDEADBEEF, 32'hFFFF0001, 1);
        drain();
        // asynchronous reset in the middle of an operation
        issue(0, 32'h01234567, 32'hF0000001, 0);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        q.delete();
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, 32'd6, 32'd7, 0);
        drain();
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'h0;
                default: ra = $urandom;
            endcase
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = -rb;
            if ($urandom_range(0, 5) == 0) begin
                drain();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)), ra, rb, 0);
        end
        drain();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
